// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size/sign codes and
// the access FSM state encoding.
package lsu_pkg;

    // funct3 size/sign codes (BU/HU are legal on loads only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Memory-side req/ack bus between the load/store unit (master) and memory (slave).
//   req    master->slave  request, held until ack
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned address
//   be     master->slave  byte enables (0000 on reads)
//   wdata  master->slave  lane-replicated store data
//   ack    slave->master  access complete; rdata valid same cycle on reads
//   rdata  slave->master  read word
interface lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
//   Store side (live request): byte enables, replicated lane data, legality.
//   Load side (registered offset/size): lane select and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [2:0]  st_funct3,
    input  logic        st_is_store,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_data,
    output logic        st_legal,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be        = '0;
        st_lane_data = st_wdata;
        st_legal     = 1'b0;
        case (st_funct3)
            F3_B: begin
                st_be        = 4'b0001 << st_off;
                st_lane_data = {4{st_wdata[7:0]}};
                st_legal     = 1'b1;
            end
            F3_H: begin
                st_be        = st_off[1] ? 4'b1100 : 4'b0011;
                st_lane_data = {2{st_wdata[15:0]}};
                st_legal     = !st_off[0];
            end
            F3_W: begin
                st_be    = 4'b1111;
                st_legal = (st_off == 2'b00);
            end
            F3_BU:   st_legal = !st_is_store;
            F3_HU:   st_legal = !st_is_store && !st_off[0];
            default: st_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one LB/LH/LW/LBU/LHU/SB/SH/SW access on a req/ack bus.
//   clk, reset          clock, async active-high reset
//   addr, wdata         effective address and store data from the core
//   mem_read/mem_write  access request; funct3 selects size/sign
//   stall               hold PC/regfile write (combinational)
//   rdata               extended load data, valid in DONE and held afterwards
//   err                 one-cycle reject/timeout indication
//   bus                 memory bus (master side)
// TIMEOUT: max REQ cycles waiting for ack before abort; 0 disables.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    lsu_if.master       bus
);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] baddr_q, baddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] bwdata_q, bwdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        to_q, to_d;
    logic [31:0] cnt_q, cnt_d;

    logic [3:0]  st_be;
    logic [31:0] st_lane;
    logic        st_legal;
    logic [31:0] ld_data;

    lsu_align u_align (
        .st_off       (addr[1:0]),
        .st_funct3    (funct3),
        .st_is_store  (mem_write),
        .st_wdata     (wdata),
        .st_be        (st_be),
        .st_lane_data (st_lane),
        .st_legal     (st_legal),
        .ld_off       (off_q),
        .ld_funct3    (f3_q),
        .ld_word      (bus.rdata),
        .ld_data      (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        baddr_d  = baddr_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        off_d    = off_q;
        f3_d     = f3_q;
        rdata_d  = rdata_q;
        to_d     = to_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    if ((mem_read && mem_write) || !st_legal) begin
                        err = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_d  = ST_REQ;
                        req_d    = 1'b1;
                        we_d     = mem_write;
                        baddr_d  = {addr[31:2], 2'b00};
                        be_d     = mem_write ? st_be : 4'b0000;
                        bwdata_d = mem_write ? st_lane : '0;
                        off_d    = addr[1:0];
                        f3_d     = funct3;
                        cnt_d    = '0;
                        to_d     = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (bus.ack) begin
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = ld_data;
                    state_d = ST_DONE;
                end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                err     = to_q;
                to_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= '0;
            be_q     <= '0;
            bwdata_q <= '0;
            off_q    <= '0;
            f3_q     <= '0;
            rdata_q  <= '0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            off_q    <= off_d;
            f3_q     <= f3_d;
            rdata_q  <= rdata_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = baddr_q;
    assign bus.be    = be_q;
    assign bus.wdata = bwdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        stall;
    logic [31:0] rdata;
    logic        err;

    lsu_if bus_if ();

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .stall     (stall),
        .rdata     (rdata),
        .err       (err),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          waits;
        logic [31:0] brd;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    logic [31:0] last_rd;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] exp;
        int          nst;
        @(negedge clk);
        mem_read  = v.rd;
        mem_write = v.wr;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wd;
        #1;
        if (v.exp_err) begin
            chk("err_illegal", {31'b0, err}, 32'd1);
            chk("stall_illegal", {31'b0, stall}, 32'd0);
            @(posedge clk);
            #1;
            chk("no_req_illegal", {31'b0, bus_if.req}, 32'd0);
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end else begin
            chk("err_idle", {31'b0, err}, 32'd0);
            nst = stall ? 1 : 0;
            exp = v.rd ? v.exp_rd : last_rd;
            sb_q.push_back(exp);
            @(negedge clk);
            chk("bus_req_rise", {31'b0, bus_if.req}, 32'd1);
            chk("bus_we", {31'b0, bus_if.we}, {31'b0, v.wr});
            chk("bus_addr", bus_if.addr, {v.addr[31:2], 2'b00});
            chk("bus_be", {28'b0, bus_if.be}, v.wr ? {28'b0, v.exp_be} : 32'd0);
            if (v.wr) chk("bus_wdata", bus_if.wdata, v.exp_bwd);
            for (int w = 0; w <= v.waits; w++) begin
                if (stall) nst++;
                chk("req_held", {31'b0, bus_if.req}, 32'd1);
                if (w == v.waits) begin
                    bus_if.ack   = 1'b1;
                    bus_if.rdata = v.brd;
                end
                @(negedge clk);
            end
            bus_if.ack   = 1'b0;
            bus_if.rdata = $urandom;
            chk("stall_done", {31'b0, stall}, 32'd0);
            chk("err_done", {31'b0, err}, 32'd0);
            chk("req_dropped", {31'b0, bus_if.req}, 32'd0);
            chk("rdata", rdata, sb_q.pop_front());
            chk("stall_cycles", nst, v.waits + 2);
            last_rd   = exp;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t v;
        n_tests      = 0;
        n_fail       = 0;
        last_rd      = '0;
        reset        = 1'b1;
        addr         = '0;
        wdata        = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        funct3       = 3'b000;
        bus_if.ack   = 1'b0;
        bus_if.rdata = '0;

        //            rd    wr    f3      addr          wdata         w  bus_rdata     err   be     bus_wdata     rdata
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h000000A5, 0, 32'h0,        1'b0, 4'h8, 32'hA5A5A5A5, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000BEEF, 0, 32'h0,        1'b0, 4'hC, 32'hBEEFBEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0100, 32'h12345678, 1, 32'h0,        1'b0, 4'h1, 32'h78787878, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0100, 32'h1234CAFE, 0, 32'h0,        1'b0, 4'h3, 32'hCAFECAFE, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        2, 32'h1234F0AA, 1'b0, 4'h0, 32'h0,        32'hFFFFFFF0});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,        2, 32'h1234F0AA, 1'b0, 4'h0, 32'h0,        32'h000000F0});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        0, 32'h80017FFF, 1'b0, 4'h0, 32'h0,        32'hFFFF8001});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        0, 32'h80017FFF, 1'b0, 4'h0, 32'h0,        32'h00008001});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,        1, 32'h80017FFF, 1'b0, 4'h0, 32'h0,        32'h00007FFF});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        3, 32'hCAFEBABE, 1'b0, 4'h0, 32'h0,        32'hCAFEBABE});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h7F000000, 1'b0, 4'h0, 32'h0,        32'h0000007F});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h000000FF, 0, 32'h0,        1'b0, 4'h2, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0103, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0});

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_bus_req", {31'b0, bus_if.req}, 32'd0);
        chk("rst_bus_be", {28'b0, bus_if.be}, 32'd0);
        chk("rst_bus_addr", bus_if.addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Hung load: abort after TIMEOUT REQ cycles
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0200;
        sb_q.push_back(32'h0);
        @(negedge clk);
        n = 0;
        while (bus_if.req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", n, 32'd16);
        chk("timeout_err", {31'b0, err}, 32'd1);
        chk("timeout_stall", {31'b0, stall}, 32'd0);
        chk("timeout_rdata", rdata, sb_q.pop_front());
        last_rd  = '0;
        mem_read = 1'b0;
        @(negedge clk);
        chk("timeout_err_clear", {31'b0, err}, 32'd0);

        // Reset mid-access, stray ack afterwards
        @(negedge clk);
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0300;
        @(negedge clk);
        chk("mid_req_up", {31'b0, bus_if.req}, 32'd1);
        #2;
        mem_read = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_rst_req", {31'b0, bus_if.req}, 32'd0);
        chk("async_rst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        reset        = 1'b0;
        bus_if.ack   = 1'b1;
        bus_if.rdata = 32'hFFFF_0055;
        #1;
        chk("stray_ack_req", {31'b0, bus_if.req}, 32'd0);
        chk("stray_ack_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        bus_if.ack = 1'b0;
        chk("stray_ack_rdata", rdata, 32'd0);
        chk("stray_ack_err", {31'b0, err}, 32'd0);
        last_rd = '0;

        v = '{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 1, 32'h13572468, 1'b0, 4'h0, 32'h0, 32'h13572468};
        run_vec(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
